// File: rtl/fifo_burst_drain.sv
// Show-ahead FIFO read master: drains a programmed word count
// into Avalon-MM write bursts, each started only once fully buffered.
module fifo_burst_drain #(
    parameter int WIDTH     = 32,
    parameter int WIDTHU    = 4,
    parameter int MAX_BURST = 8,
    parameter int BURSTW    = 4,
    parameter int CNTW      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       start_address,
    input  logic [CNTW-1:0]   start_count,
    output logic              busy,
    output logic              done,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [WIDTHU-1:0] fifo_usedw,
    input  logic [WIDTH-1:0]  fifo_q,
    output logic              fifo_rdreq,
    output logic [31:0]       avm_address,
    output logic              avm_write,
    output logic [WIDTH-1:0]  avm_writedata,
    output logic [BURSTW-1:0] avm_burstcount,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        BURST
    } state_t;

    localparam logic [CNTW-1:0] MAXB  = CNTW'(MAX_BURST);
    localparam logic [31:0]     BYTES = 32'(WIDTH / 8);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       addr;
    logic [CNTW-1:0]   remaining;
    logic [CNTW-1:0]   burst_len;
    logic [CNTW-1:0]   rem_after;
    logic [CNTW-1:0]   avail_w;
    logic [WIDTHU:0]   avail;
    logic [BURSTW-1:0] beats;
    logic              data_ok;
    logic              beat_ok;
    logic              last_beat;

    // usedw wraps to zero when full, so the full flag supplies the top bit
    assign avail     = fifo_full ? {1'b1, {WIDTHU{1'b0}}}
                                 : {1'b0, fifo_usedw};
    assign avail_w   = CNTW'(avail);
    assign burst_len = (remaining < MAXB) ? remaining : MAXB;
    assign data_ok   = !fifo_empty && (avail_w >= burst_len);

    assign avm_write     = (state == BURST);
    assign avm_writedata = fifo_q;
    assign beat_ok       = avm_write & ~avm_waitrequest;
    assign fifo_rdreq    = beat_ok;
    assign last_beat     = beat_ok && (beats == BURSTW'(1));
    assign rem_after     = remaining - CNTW'(avm_burstcount);
    assign busy          = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && start_count != '0)
                    state_nxt = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (data_ok)
                    state_nxt = BURST;
            end
            BURST: begin
                if (last_beat)
                    state_nxt = (rem_after == '0) ? IDLE : WAIT_DATA;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer counters, burst outputs and the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr           <= '0;
            remaining      <= '0;
            beats          <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (start_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr      <= start_address;
                            remaining <= start_count;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (data_ok) begin
                        avm_address    <= addr;
                        avm_burstcount <= BURSTW'(burst_len);
                        beats          <= BURSTW'(burst_len);
                    end
                end
                BURST: begin
                    if (beat_ok) begin
                        beats <= beats - 1'b1;
                        if (last_beat) begin
                            remaining <= rem_after;
                            addr      <= addr + 32'(avm_burstcount) * BYTES;
                            if (rem_after == '0)
                                done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain with a queue-based FIFO,
// randomized producer and randomized slave stalls.
module tb_fifo_burst_drain;

    localparam int WIDTH  = 32;
    localparam int WIDTHU = 4;
    localparam int MAXB   = 8;
    localparam int BURSTW = 4;
    localparam int CNTW   = 16;
    localparam int DEPTH  = 1 << WIDTHU;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       start_address = '0;
    logic [CNTW-1:0]   start_count = '0;
    logic              busy;
    logic              done;
    logic              fifo_empty;
    logic              fifo_full;
    logic [WIDTHU-1:0] fifo_usedw;
    logic [WIDTH-1:0]  fifo_q;
    logic              fifo_rdreq;
    logic [31:0]       avm_address;
    logic              avm_write;
    logic [WIDTH-1:0]  avm_writedata;
    logic [BURSTW-1:0] avm_burstcount;
    logic              avm_waitrequest = 1'b0;

    fifo_burst_drain #(
        .WIDTH(WIDTH), .WIDTHU(WIDTHU), .MAX_BURST(MAXB),
        .BURSTW(BURSTW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .start_address(start_address), .start_count(start_count),
        .busy(busy), .done(done),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_usedw(fifo_usedw), .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          bc;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] exp_data[$];
    logic [31:0] fq[$];
    int          fcnt = 0;
    logic [31:0] fhead = '0;
    int          prod_mode = 0;
    int          wr_mode = 0;
    int          pcnt = 0;
    int          n_pops = 0;
    int          n_done = 0;
    int          exp_done = 0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;

    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_usedw = WIDTHU'(fcnt);
    assign fifo_q     = fhead;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO model: pop on rdreq, then optional producer push
    always @(posedge clk) begin
        logic [31:0] w;
        bit          push;
        if (fifo_rdreq && fq.size() > 0) begin
            void'(fq.pop_front());
            n_pops++;
        end
        pcnt++;
        push = 1'b0;
        case (prod_mode)
            1: push = 1'b1;
            2: push = (pcnt % 3 == 0);
            3: push = ($urandom_range(0, 1) == 1);
            default: push = 1'b0;
        endcase
        if (push && fq.size() < DEPTH) begin
            w = $urandom;
            fq.push_back(w);
            exp_data.push_back(w);
        end
        fcnt  <= fq.size();
        fhead <= (fq.size() > 0) ? fq[0] : '0;
    end

    // Slave stall driver
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            1: avm_waitrequest = ~avm_waitrequest;
            2: avm_waitrequest = ($urandom_range(0, 2) == 0);
            default: avm_waitrequest = 1'b0;
        endcase
    end

    // Monitor: scoreboard pops on every accepted beat
    bit          prev_write = 1'b0;
    bit          prev_stall = 1'b0;
    bit          done_due = 1'b0;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_bc;

    always @(negedge clk) begin
        beat_t       e;
        logic [31:0] d;
        if (!mon_en) begin
            prev_write = 1'b0;
            prev_stall = 1'b0;
            done_due   = 1'b0;
        end else begin
            assert (!(fifo_rdreq && fifo_empty))
            else begin
                n_err++;
                $display("FAIL rdreq_on_empty at %0t", $time);
            end
            chk("rdreq", fifo_rdreq, avm_write && !avm_waitrequest);
            if (avm_write && !prev_write)
                chk("burst_prefilled", fcnt >= int'(avm_burstcount), 1);
            if (prev_stall) begin
                chk("stall_write", avm_write, 1);
                chk("stall_addr", avm_address, p_addr);
                chk("stall_bc", avm_burstcount, p_bc);
                chk("stall_data", avm_writedata, p_data);
            end
            if (done_due) begin
                chk("done_after_last", done, 1);
                chk("idle_after_last", busy, 0);
                done_due = 1'b0;
            end
            if (done) n_done++;
            if (avm_write && !avm_waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", avm_address, 32'hdead_beef);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", avm_address, e.a);
                    chk("burstcount", avm_burstcount, e.bc);
                    d = (exp_data.size() > 0) ? exp_data.pop_front() : 'x;
                    chk("data", avm_writedata, d);
                    if (e.last) done_due = 1'b1;
                end
            end
            prev_write = avm_write;
            prev_stall = avm_write && avm_waitrequest;
            p_addr     = avm_address;
            p_bc       = avm_burstcount;
            p_data     = avm_writedata;
        end
    end

    task automatic clear_fifo();
        prod_mode = 0;
        fq.delete();
        exp_data.delete();
        fcnt  = 0;
        fhead = '0;
    endtask

    task automatic preload(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + 32'(i));
            exp_data.push_back(base + 32'(i));
        end
        fcnt  = fq.size();
        fhead = fq[0];
    endtask

    task automatic do_start(input logic [31:0] a, input int n);
        logic [31:0] aa;
        int          rem;
        int          len;
        aa  = a;
        rem = n;
        while (rem > 0) begin
            len = (rem < MAXB) ? rem : MAXB;
            for (int i = 0; i < len; i++) begin
                beat_t e;
                e.a    = aa;
                e.bc   = len;
                e.last = (i == len - 1) && (rem == len);
                exp_q.push_back(e);
            end
            aa  = aa + 32'(len * (WIDTH / 8));
            rem = rem - len;
        end
        exp_done++;
        start_address = a;
        start_count   = CNTW'(n);
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        bit hit;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_bc", avm_burstcount, 0);
        chk("rst_rdreq", fifo_rdreq, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic 8-word burst with start-to-write latency
        clear_fifo();
        preload(8, 32'h100);
        p0 = n_pops;
        do_start(32'h1000, 8);
        chk("lat_busy", busy, 1);
        chk("lat_write0", avm_write, 0);
        @(posedge clk); #1;
        chk("lat_write1", avm_write, 1);
        wait_idle();
        chk("basic_pops", n_pops - p0, 8);

        // Split transfer with continuous refill
        clear_fifo();
        prod_mode = 1;
        p0 = n_pops;
        do_start(32'h1000, 20);
        wait_idle();
        chk("split_pops", n_pops - p0, 20);

        // Backpressure toggling every cycle
        clear_fifo();
        preload(4, 32'h200);
        wr_mode = 1;
        p0 = n_pops;
        do_start(32'h2000, 4);
        wait_idle();
        chk("bp_pops", n_pops - p0, 4);
        wr_mode = 0;

        // Starvation: one word every third cycle
        clear_fifo();
        prod_mode = 2;
        do_start(32'h3000, 16);
        wait_idle();

        // Full FIFO reports usedw=0; burst must still start
        clear_fifo();
        preload(16, 32'h400);
        do_start(32'h4000, 16);
        @(posedge clk); #1;
        chk("full_start", avm_write, 1);
        wait_idle();

        // Zero count
        clear_fifo();
        do_start(32'h5000, 0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_write", avm_write, 0);
        @(posedge clk); #1;

        // Start while busy is ignored
        clear_fifo();
        preload(8, 32'h600);
        do_start(32'h6000, 8);
        start_address = 32'h7000;
        start_count   = CNTW'(5);
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // Address wrap
        clear_fifo();
        prod_mode = 1;
        do_start(32'hFFFF_FFE0, 16);
        wait_idle();

        // Randomized transfers with random stalls and producer
        for (int t = 0; t < 8; t++) begin
            clear_fifo();
            prod_mode = 3;
            wr_mode   = 2;
            do_start($urandom & 32'hFFFF_FFFC, $urandom_range(1, 40));
            wait_idle();
        end
        wr_mode = 0;

        // Reset in the middle of a burst
        clear_fifo();
        prod_mode = 1;
        do_start(32'h8000, 40);
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (avm_write) begin
                hit = 1'b1;
                break;
            end
        end
        chk("mid_reached", hit, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_write", avm_write, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_addr", avm_address, 0);
        chk("mid_rdreq", fifo_rdreq, 0);
        clear_fifo();
        exp_q.delete();
        exp_done--;
        @(posedge clk); #1;
        mon_en = 1'b1;
        preload(4, 32'h900);
        do_start(32'h9000, 4);
        wait_idle();

        chk("done_pulses", n_done, exp_done);
        chk("leftover_beats", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
